serial_sub: RTL and testbench
=============================

// Module: serial_sub
// PURPOSE
//  Bit-serial subtractor: computes D = A - B - BIN over WIDTH cycles, one bit per cycle,
//  using a single full-subtractor cell and a registered borrow.
//  Small-area counterpart to the ripple adder path; used by multi-cycle ALU ops (compare, SUB).
//  Start/done handshake to the ALU sequencer. Result registers held until the next start.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 2 (even when SERIAL_SUB_RADIX4_EN)
// PORTS
//  clk      in   1      system clock, rising edge
//  rstn     in   1      asynchronous active-low reset
//  start    in   1      request; sampled only in IDLE
//  a        in   WIDTH  minuend; captured when start accepted
//  b        in   WIDTH  subtrahend; captured when start accepted
//  bin      in   1      borrow-in; captured when start accepted
//  busy     out  1      high from the cycle after acceptance until done
//  done     out  1      one-cycle pulse: d and flags valid
//  d        out  WIDTH  difference, modulo 2^WIDTH
//  bout     out  1      final borrow (1 = unsigned a < b + bin)
//  ovf      out  1      signed overflow
//  zero     out  1      d == 0
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy=0, done=0, d=0, bout=0, ovf=0, zero=0.
//  - Full-subtractor cell per bit: diff = a^b^brw; brw_next = (~a&b) | (~(a^b)&brw).
//  - FSM states IDLE, RUN, DONE:
//    IDLE: if start, latch a/b into shift regs, brw<=bin, cnt<=0, go RUN. Otherwise hold.
//    RUN: each cycle, process LSB of shift regs; shift diff bit into d from MSB side; cnt++.
//      Leave RUN after bit WIDTH-1, go DONE.
//    DONE: done=1 for exactly one cycle; then IDLE.
//  - Latency: start sampled at edge 0 -> done high in cycle WIDTH+1.
//    WIDTH=16: done is high in the 17th cycle after the accepting edge.
//  - busy=1 throughout RUN, 0 in IDLE and DONE. start during RUN/DONE is ignored, not queued.
//  - Flags update in the DONE cycle only: bout = final brw; zero = (d==0);
//    ovf = (a[MSB]!=b[MSB]) & (d[MSB]!=a[MSB]), using the latched operand MSBs.
//  - d/flags keep their value from the end of DONE until the next accepted start.
//    d is not cleared on start and is undefined-for-use while busy=1 (partial shifts visible).
//  - start held high continuously: a new op is accepted on each return to IDLE
//    (back-to-back throughput WIDTH+2 cycles).
//  - rstn asserted mid-RUN: op aborted, all outputs to reset values, no done pulse.
//  - Counter width clog2(WIDTH)+1; no wrap; terminal compare is cnt==WIDTH-1.
// CONFIGURATION
//  SERIAL_SUB_RADIX4_EN defined: two cascaded cells per cycle, 2 bits/cycle.
//    RUN lasts WIDTH/2 cycles; done appears in cycle WIDTH/2+1 (9 for WIDTH=16).
//    WIDTH must be even; elaboration error otherwise.
//  SERIAL_SUB_RADIX4_EN undefined: 1 bit/cycle as above. Results identical in both builds.
// TESTING (WIDTH=16, run in both builds; latency checks per build)
//  a=0x0005 b=0x0003 bin=0 -> d=0x0002 bout=0 ovf=0 zero=0; done exactly at cycle 17 (9 radix4).
//  a=0x0000 b=0x0001 bin=0 -> d=0xFFFF bout=1 ovf=0 zero=0.
//  a=0x8000 b=0x0001 bin=0 -> d=0x7FFF bout=0 ovf=1.
//  a=0x0005 b=0x0004 bin=1 -> d=0x0000 zero=1 bout=0.
//  Start accepted, then start with a=0xFFFF pulsed mid-RUN -> ignored; result of first op;
//    single done pulse.
//  rstn low at RUN cycle 5 -> all outputs 0; no done; next op after release completes correctly.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor D = A - B - BIN using one full-subtractor cell and a registered borrow.
// Latency: start accepted at edge 0, done pulses in cycle WIDTH+1 (WIDTH/2+1 with SERIAL_SUB_RADIX4_EN).
// Backpressure: none; start is only sampled in IDLE, and a start during RUN/DONE is dropped rather than queued.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start, a, b, bin   request plus operands, captured when start is accepted in IDLE
//   busy               high while bits are being processed (RUN)
//   done               one-cycle pulse; d and flags valid from this cycle until the next accepted start
//   d, bout, ovf, zero difference mod 2^WIDTH, final borrow, signed overflow, d == 0
//
// Build option: define SERIAL_SUB_RADIX4_EN to process two bits per cycle (WIDTH must be even).
module serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef SERIAL_SUB_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  // Terminal count: the last RUN cycle is the one that handles the top bit(s).
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / STEP - 1);

  if (WIDTH < 2) begin : gWidthMin
    $error("serial_sub: WIDTH must be >= 2");
  end

  if ((WIDTH % STEP) != 0) begin : gWidthEven
    $error("serial_sub: WIDTH must be even for the two-bit-per-cycle build");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] aSh, bSh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             aMsb, bMsb;

  logic [1:0]       cell0;
  logic [WIDTH-1:0] dShift;
  logic             brwNext;
  logic             lastStep;

  // Full-subtractor cell, returns {borrowOut, diff}.
  function automatic logic [1:0] fullSub(input logic x, input logic y, input logic bi);
    logic diffBit;
    logic borrowOut;
    diffBit   = x ^ y ^ bi;
    borrowOut = (~x & y) | (~(x ^ y) & bi);
    return {borrowOut, diffBit};
  endfunction

`ifdef SERIAL_SUB_RADIX4_EN
  logic [1:0] cell1;

  // Two cascaded cells: bit 0 feeds its borrow into bit 1 within the same cycle.
  always_comb begin
    cell0   = fullSub(aSh[0], bSh[0], brw);
    cell1   = fullSub(aSh[1], bSh[1], cell0[1]);
    brwNext = cell1[1];
    // Results enter from the MSB side so after the last step bit 0 sits at d[0].
    dShift            = d >> 2;
    dShift[WIDTH-1]   = cell1[0];
    dShift[WIDTH-2]   = cell0[0];
  end
`else
  always_comb begin
    cell0           = fullSub(aSh[0], bSh[0], brw);
    brwNext         = cell0[1];
    dShift          = d >> 1;
    dShift[WIDTH-1] = cell0[0];
  end
`endif

  assign lastStep = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (lastStep) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath. Flags are written on the final RUN edge so they are valid
  // together with the done pulse and then held until the next op finishes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aSh  <= '0;
      bSh  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      aMsb <= 1'b0;
      bMsb <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aSh  <= a;
            bSh  <= b;
            brw  <= bin;
            cnt  <= '0;
            // Shift registers lose the MSBs, keep them for the overflow flag.
            aMsb <= a[WIDTH-1];
            bMsb <= b[WIDTH-1];
          end
        end
        RUN: begin
          aSh <= aSh >> STEP;
          bSh <= bSh >> STEP;
          brw <= brwNext;
          d   <= dShift;
          cnt <= cnt + CW'(1);
          if (lastStep) begin
            bout <= brwNext;
            zero <= (dShift == '0);
            ovf  <= (aMsb != bMsb) & (dShift[WIDTH-1] != aMsb);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

  localparam int W = 16;
`ifdef SERIAL_SUB_RADIX4_EN
  localparam int LAT = W / 2 + 1;
`else
  localparam int LAT = W + 1;
`endif
  localparam int PERIOD_B2B = LAT + 1;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         zero;

  int total;
  int bad;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .ovf  (ovf),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] expD;
    logic         expBout;
    logic         expOvf;
    logic         expZero;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Issues one op from IDLE and returns the cycle (counted from the accepting
  // edge) in which done was seen, or -1 if it never came. Returns sampled at
  // the negedge of the done cycle.
  task automatic runOp(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vbin, output int lat);
    @(negedge clk);
    a     = va;
    b     = vb;
    bin   = vbin;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int nDone;
    int firstDone;
    int doneAt[$];
    logic [W-1:0] heldD;

    total = 0;
    bad   = 0;

    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 1'b0};

    rstn  = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset d",    32'(d),    32'd0);
    check("reset bout", 32'(bout), 32'd0);
    check("reset ovf",  32'(ovf),  32'd0);
    check("reset zero", 32'(zero), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      runOp(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d d", i),    32'(d),    32'(vecs[i].expD));
      check($sformatf("vec%0d bout", i), 32'(bout), 32'(vecs[i].expBout));
      check($sformatf("vec%0d ovf", i),  32'(ovf),  32'(vecs[i].expOvf));
      check($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].expZero));
      check($sformatf("vec%0d busy in done", i), 32'(busy), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), 32'(done), 32'd0);
      check($sformatf("vec%0d d held", i), 32'(d), 32'(vecs[i].expD));
    end

    // busy during RUN, start mid-RUN ignored, single done pulse
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nDone = 0;
    firstDone = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) check("busy in RUN", 32'(busy), 32'd1);
      if (k == 3) begin
        a = 16'hFFFF; b = 16'h0000; bin = 1'b0; start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        nDone++;
        if (firstDone < 0) firstDone = k;
        heldD = d;
      end
    end
    check("midrun start latency", 32'(firstDone), 32'(LAT));
    check("midrun start done count", 32'(nDone), 32'd1);
    check("midrun start d", 32'(heldD), 32'h0002);
    check("midrun start d held", 32'(d), 32'h0002);

    // reset in the middle of RUN after a result with nonzero flags
    runOp(16'hA5A5, 16'h5A5A, 1'b0, lat);
    check("pre-abort ovf", 32'(ovf), 32'd1);
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort d",    32'(d),    32'd0);
    check("abort bout", 32'(bout), 32'd0);
    check("abort ovf",  32'(ovf),  32'd0);
    check("abort zero", 32'(zero), 32'd0);
    nDone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 2) rstn = 1'b1;
      if (done || busy) nDone++;
    end
    check("abort no done/busy", 32'(nDone), 32'd0);
    runOp(16'h0005, 16'h0003, 1'b0, lat);
    check("post-abort latency", 32'(lat), 32'(LAT));
    check("post-abort d",       32'(d),   32'h0002);
    check("post-abort bout",    32'(bout), 32'd0);

    // start held high: back-to-back ops every LAT+1 cycles
    @(negedge clk);
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 4 * PERIOD_B2B; k++) begin
      @(negedge clk);
      if (done) doneAt.push_back(k);
    end
    start = 1'b0;
    check("b2b done count", 32'(doneAt.size()), 32'd4);
    if (doneAt.size() >= 2) begin
      check("b2b period", 32'(doneAt[1] - doneAt[0]), 32'(PERIOD_B2B));
    end
    check("b2b d", 32'(d), 32'h7FFF);
    repeat (PERIOD_B2B + 2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
